// File: rtl/udma_stream_ring_unit.sv
// Ring-buffer stream unit: follows a producer's spoofed L2 writes into a circular
// buffer, reads the data back over a uDMA TX channel and streams it out via a FIFO.
//
// state | meaning
// IDLE  | passthrough, in_stream mirrored to out_stream
// ARMED | waiting for the first producer write to latch pointer and datasize
// RUN   | tracking writes and issuing credit-limited reads
// DRAIN | no new reads; waiting for in-flight data and the FIFO to empty
module udma_stream_ring_unit #(
   parameter int L2_AWIDTH_NOAL  = 16,
   parameter int DATA_WIDTH      = 32,
   parameter int STREAM_ID_WIDTH = 2,
   parameter int INST_ID         = 0,
   parameter int FIFO_DEPTH      = 4
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        cfg_en_i,
   input  logic                        cfg_clr_i,
   input  logic [L2_AWIDTH_NOAL-1:0]   cfg_base_i,
   input  logic [L2_AWIDTH_NOAL-1:0]   cfg_size_i,
   output logic                        tx_ch_req_o,
   output logic [L2_AWIDTH_NOAL-1:0]   tx_ch_addr_o,
   output logic [1:0]                  tx_ch_datasize_o,
   input  logic                        tx_ch_gnt_i,
   input  logic                        tx_ch_valid_i,
   input  logic [DATA_WIDTH-1:0]       tx_ch_data_i,
   output logic                        tx_ch_ready_o,
   input  logic [STREAM_ID_WIDTH-1:0]  in_stream_dest_i,
   input  logic [DATA_WIDTH-1:0]       in_stream_data_i,
   input  logic [1:0]                  in_stream_datasize_i,
   input  logic                        in_stream_valid_i,
   input  logic                        in_stream_sot_i,
   input  logic                        in_stream_eot_i,
   output logic                        in_stream_ready_o,
   output logic [DATA_WIDTH-1:0]       out_stream_data_o,
   output logic [1:0]                  out_stream_datasize_o,
   output logic                        out_stream_valid_o,
   output logic                        out_stream_sot_o,
   output logic                        out_stream_eot_o,
   input  logic                        out_stream_ready_i,
   input  logic [L2_AWIDTH_NOAL-1:0]   spoof_addr_i,
   input  logic [STREAM_ID_WIDTH-1:0]  spoof_dest_i,
   input  logic [1:0]                  spoof_datasize_i,
   input  logic                        spoof_req_i,
   input  logic                        spoof_gnt_i,
   output logic                        err_overrun_o,
   output logic                        err_fmt_o,
   output logic [L2_AWIDTH_NOAL:0]     level_o
);

   localparam int AW = L2_AWIDTH_NOAL;
   localparam int DW = DATA_WIDTH;
   localparam int SW = STREAM_ID_WIDTH;
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_ARMED = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_DRAIN = 2'd3;

   localparam logic [SW-1:0] MY_ID      = SW'(INST_ID);
   localparam logic [CW:0]   CREDIT_MAX = (CW+1)'(FIFO_DEPTH);

   function automatic logic [2:0] inc_of(input logic [1:0] ds);
      case (ds)
         2'd0:    inc_of = 3'd1;
         2'd1:    inc_of = 3'd2;
         2'd2:    inc_of = 3'd4;
         default: inc_of = 3'd0;
      endcase
   endfunction

   logic [1:0]    r_state, s_state_nxt;
   logic [1:0]    r_datasize;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_level;
   logic [CW-1:0] r_inflight;
   logic [CW-1:0] r_wptr, r_rptr;
   logic [DW-1:0] r_fifo [FIFO_DEPTH];
   logic          r_sot_pend, r_err_overrun, r_err_fmt;

   logic [2:0]    s_inc, s_inc_spoof;
   logic          s_write, s_w_ok, s_grant, s_push, s_pop, s_ring_out, s_fifo_empty, s_overrun;
   logic [CW-1:0] s_fifo_cnt;
   logic [CW:0]   s_credit_used;
   logic [AW:0]   s_ptr_sum, s_ring_end;
   logic [AW-1:0] s_ptr_wrap;
   logic [AW+1:0] s_lvl_sum;
   logic          unused_dest;

   assign unused_dest = ^in_stream_dest_i;

   assign s_inc         = inc_of(r_datasize);
   assign s_inc_spoof   = inc_of(spoof_datasize_i);
   assign s_write       = spoof_req_i & spoof_gnt_i & (spoof_dest_i == MY_ID);
   assign s_w_ok        = s_write & (spoof_datasize_i == r_datasize) & (spoof_datasize_i != 2'd3);
   assign s_fifo_cnt    = r_wptr - r_rptr;
   assign s_fifo_empty  = (r_wptr == r_rptr);
   assign s_credit_used = (CW+1)'(r_inflight) + (CW+1)'(s_fifo_cnt);

   // Credits cover both in-flight reads and FIFO occupancy, so the FIFO can never overflow.
   assign tx_ch_req_o = (r_state == ST_RUN) && (s_inc != 3'd0) &&
                        (r_level >= (AW+1)'(s_inc)) && (s_credit_used < CREDIT_MAX);
   assign s_grant     = tx_ch_req_o & tx_ch_gnt_i;
   // Returning data is only accepted while reads are outstanding; data after a clear is dropped.
   assign s_push      = tx_ch_valid_i & (r_inflight != '0);
   assign s_ring_out  = (r_state != ST_IDLE);
   assign s_pop       = s_ring_out & ~s_fifo_empty & out_stream_ready_i;

   assign s_ptr_sum  = {1'b0, r_rd_ptr} + (AW+1)'(s_inc);
   assign s_ring_end = {1'b0, cfg_base_i} + {1'b0, cfg_size_i};
   assign s_ptr_wrap = AW'((s_ptr_sum >= s_ring_end) ? s_ptr_sum - {1'b0, cfg_size_i} : s_ptr_sum);

   assign s_lvl_sum = {1'b0, r_level} + (s_w_ok ? (AW+2)'(s_inc) : '0) - (s_grant ? (AW+2)'(s_inc) : '0);
   assign s_overrun = s_w_ok & (s_lvl_sum > {2'b00, cfg_size_i});

   always_comb begin
      s_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (cfg_en_i) s_state_nxt = ST_ARMED;
         ST_ARMED: begin
            if (!cfg_en_i)                                s_state_nxt = ST_IDLE;
            else if (s_write && spoof_datasize_i != 2'd3) s_state_nxt = ST_RUN;
         end
         ST_RUN:   if (!cfg_en_i) s_state_nxt = ST_DRAIN;
         default:  if (r_inflight == '0 && s_fifo_empty) s_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state       <= ST_IDLE;
         r_datasize    <= '0;
         r_rd_ptr      <= '0;
         r_level       <= '0;
         r_inflight    <= '0;
         r_wptr        <= '0;
         r_rptr        <= '0;
         r_sot_pend    <= 1'b0;
         r_err_overrun <= 1'b0;
         r_err_fmt     <= 1'b0;
      end else if (cfg_clr_i) begin
         r_state       <= ST_IDLE;
         r_datasize    <= '0;
         r_rd_ptr      <= '0;
         r_level       <= '0;
         r_inflight    <= '0;
         r_wptr        <= '0;
         r_rptr        <= '0;
         r_sot_pend    <= 1'b0;
         r_err_overrun <= 1'b0;
         r_err_fmt     <= 1'b0;
      end else begin
         r_state    <= s_state_nxt;
         r_inflight <= r_inflight + CW'(s_grant) - CW'(s_push);
         if (s_push) r_wptr <= r_wptr + 1'b1;
         if (s_pop) begin
            r_rptr     <= r_rptr + 1'b1;
            r_sot_pend <= 1'b0;
         end
         case (r_state)
            ST_ARMED: begin
               if (s_state_nxt == ST_RUN) begin
                  r_datasize <= spoof_datasize_i;
                  r_rd_ptr   <= spoof_addr_i;
                  r_level    <= (AW+1)'(s_inc_spoof);
                  r_sot_pend <= 1'b1;
               end else if (cfg_en_i && s_write && spoof_datasize_i == 2'd3) begin
                  r_err_fmt <= 1'b1;
               end
            end
            ST_RUN: begin
               if (s_grant) r_rd_ptr <= s_ptr_wrap;
               if (s_overrun) begin
                  r_err_overrun <= 1'b1;
                  r_level       <= {1'b0, cfg_size_i};
               end else begin
                  r_level <= s_lvl_sum[AW:0];
               end
               if (s_write && !s_w_ok) r_err_fmt <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i) begin
      if (s_push) r_fifo[r_wptr[PW-1:0]] <= tx_ch_data_i;
   end

   assign tx_ch_addr_o     = r_rd_ptr;
   assign tx_ch_datasize_o = r_datasize;
   assign tx_ch_ready_o    = 1'b1;

   assign in_stream_ready_o     = s_ring_out ? 1'b0 : out_stream_ready_i;
   assign out_stream_data_o     = s_ring_out ? r_fifo[r_rptr[PW-1:0]] : in_stream_data_i;
   assign out_stream_datasize_o = s_ring_out ? r_datasize : in_stream_datasize_i;
   assign out_stream_valid_o    = s_ring_out ? ~s_fifo_empty : in_stream_valid_i;
   assign out_stream_sot_o      = s_ring_out ? (r_sot_pend & ~s_fifo_empty) : in_stream_sot_i;
   assign out_stream_eot_o      = s_ring_out ? 1'b0 : in_stream_eot_i;

   assign err_overrun_o = r_err_overrun;
   assign err_fmt_o     = r_err_fmt;
   assign level_o       = r_level;

endmodule

// File: tb/tb_udma_stream_ring_unit.sv
// Bench for udma_stream_ring_unit: passthrough vector table, randomized ring traffic
// against a queue-based L2/stream model, and directed error/credit/clear sequences.
module tb_udma_stream_ring_unit;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int SW = 2;
   localparam logic [SW-1:0] INST  = 2'd0;
   localparam logic [SW-1:0] OTHER = 2'd1;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          cfg_en_i, cfg_clr_i;
   logic [AW-1:0] cfg_base_i, cfg_size_i;
   logic          tx_ch_req_o;
   logic [AW-1:0] tx_ch_addr_o;
   logic [1:0]    tx_ch_datasize_o;
   logic          tx_ch_gnt_i, tx_ch_valid_i, tx_ch_ready_o;
   logic [DW-1:0] tx_ch_data_i;
   logic [SW-1:0] in_stream_dest_i;
   logic [DW-1:0] in_stream_data_i;
   logic [1:0]    in_stream_datasize_i;
   logic          in_stream_valid_i, in_stream_sot_i, in_stream_eot_i, in_stream_ready_o;
   logic [DW-1:0] out_stream_data_o;
   logic [1:0]    out_stream_datasize_o;
   logic          out_stream_valid_o, out_stream_sot_o, out_stream_eot_o, out_stream_ready_i;
   logic [AW-1:0] spoof_addr_i;
   logic [SW-1:0] spoof_dest_i;
   logic [1:0]    spoof_datasize_i;
   logic          spoof_req_i, spoof_gnt_i;
   logic          err_overrun_o, err_fmt_o;
   logic [AW:0]   level_o;

   always #5 clk_i = ~clk_i;

   udma_stream_ring_unit #(
      .L2_AWIDTH_NOAL(AW), .DATA_WIDTH(DW), .STREAM_ID_WIDTH(SW), .INST_ID(0), .FIFO_DEPTH(4)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .cfg_en_i(cfg_en_i), .cfg_clr_i(cfg_clr_i),
      .cfg_base_i(cfg_base_i), .cfg_size_i(cfg_size_i),
      .tx_ch_req_o(tx_ch_req_o), .tx_ch_addr_o(tx_ch_addr_o), .tx_ch_datasize_o(tx_ch_datasize_o),
      .tx_ch_gnt_i(tx_ch_gnt_i), .tx_ch_valid_i(tx_ch_valid_i), .tx_ch_data_i(tx_ch_data_i),
      .tx_ch_ready_o(tx_ch_ready_o),
      .in_stream_dest_i(in_stream_dest_i), .in_stream_data_i(in_stream_data_i),
      .in_stream_datasize_i(in_stream_datasize_i), .in_stream_valid_i(in_stream_valid_i),
      .in_stream_sot_i(in_stream_sot_i), .in_stream_eot_i(in_stream_eot_i),
      .in_stream_ready_o(in_stream_ready_o),
      .out_stream_data_o(out_stream_data_o), .out_stream_datasize_o(out_stream_datasize_o),
      .out_stream_valid_o(out_stream_valid_o), .out_stream_sot_o(out_stream_sot_o),
      .out_stream_eot_o(out_stream_eot_o), .out_stream_ready_i(out_stream_ready_i),
      .spoof_addr_i(spoof_addr_i), .spoof_dest_i(spoof_dest_i), .spoof_datasize_i(spoof_datasize_i),
      .spoof_req_i(spoof_req_i), .spoof_gnt_i(spoof_gnt_i),
      .err_overrun_o(err_overrun_o), .err_fmt_o(err_fmt_o), .level_o(level_o)
   );

   typedef struct {
      logic [31:0] data;
      logic [1:0]  ds;
      logic        valid, sot, eot, rdy;
      logic [31:0] e_data;
      logic [1:0]  e_ds;
      logic        e_valid, e_sot, e_eot, e_in_ready;
   } pt_vec_t;

   pt_vec_t     pt_tab [4];
   int          errors = 0;
   int          checks = 0;
   int          lvl, granted, popped, responded, kind, ngr;
   logic [15:0] wr_addr, rd_exp;
   logic        running, first_beat, w_ev, exp_req, vnext;
   logic [31:0] wdata;
   logic [31:0] exp_q [$];
   logic [31:0] pend_q [$];
   logic [31:0] mem [4];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_defaults();
      cfg_clr_i = 1'b0; tx_ch_gnt_i = 1'b0; tx_ch_valid_i = 1'b0; tx_ch_data_i = '0;
      in_stream_dest_i = '0; in_stream_data_i = '0; in_stream_datasize_i = '0;
      in_stream_valid_i = 1'b0; in_stream_sot_i = 1'b0; in_stream_eot_i = 1'b0;
      out_stream_ready_i = 1'b0; spoof_addr_i = '0; spoof_dest_i = INST;
      spoof_datasize_i = 2'd2; spoof_req_i = 1'b0; spoof_gnt_i = 1'b0;
   endtask

   task automatic write_ev(input logic [15:0] a, input logic [1:0] ds);
      spoof_addr_i = a; spoof_datasize_i = ds; spoof_dest_i = INST;
      spoof_req_i = 1'b1; spoof_gnt_i = 1'b1;
   endtask

   task automatic no_write();
      spoof_req_i = 1'b0; spoof_gnt_i = 1'b0;
   endtask

   task automatic clear();
      cfg_clr_i = 1'b1;
      tick();
      cfg_clr_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i = 1'b1;
      drive_defaults();
      cfg_en_i = 1'b0; cfg_base_i = '0; cfg_size_i = '0;
      #23;
      chk("rst_req", tx_ch_req_o, 0);
      chk("rst_oval", out_stream_valid_o, 0);
      chk("rst_err", {err_overrun_o, err_fmt_o}, 0);
      chk("rst_level", level_o, 0);
      rst_i = 1'b0;
      tick();

      // passthrough vectors: out_stream must mirror in_stream, in_ready mirrors out_ready
      pt_tab[0] = '{32'hA5A5_0001, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1, 32'hA5A5_0001, 2'd2, 1'b1, 1'b1, 1'b0, 1'b1};
      pt_tab[1] = '{32'h0000_BEEF, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_BEEF, 2'd1, 1'b1, 1'b0, 1'b0, 1'b1};
      pt_tab[2] = '{32'h1234_5678, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h1234_5678, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1};
      pt_tab[3] = '{32'hFFFF_0000, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_0000, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0};
      for (int i = 0; i < 4; i++) begin
         in_stream_data_i = pt_tab[i].data; in_stream_datasize_i = pt_tab[i].ds;
         in_stream_valid_i = pt_tab[i].valid; in_stream_sot_i = pt_tab[i].sot;
         in_stream_eot_i = pt_tab[i].eot; out_stream_ready_i = pt_tab[i].rdy;
         #1;
         chk("pt_data", out_stream_data_o, pt_tab[i].e_data);
         chk("pt_ctl", {out_stream_datasize_o, out_stream_valid_o, out_stream_sot_o, out_stream_eot_o},
             {pt_tab[i].e_ds, pt_tab[i].e_valid, pt_tab[i].e_sot, pt_tab[i].e_eot});
         chk("pt_in_ready", in_stream_ready_o, pt_tab[i].e_in_ready);
         chk("pt_req", tx_ch_req_o, 0);
         tick();
      end
      drive_defaults();

      // randomized ring traffic, 16B ring at 0x100, then drain
      clear();
      cfg_base_i = 16'h0100; cfg_size_i = 16'h0010; cfg_en_i = 1'b1;
      tick();
      lvl = 0; granted = 0; popped = 0; responded = 0;
      wr_addr = 16'h0100; rd_exp = 16'h0100; running = 1'b0; first_beat = 1'b1;
      for (int cyc = 0; cyc < 700; cyc++) begin
         if (cyc > 300 && granted == popped && responded == granted) break;
         cfg_en_i = (cyc < 300);
         chk("level", level_o, lvl);
         kind = $urandom_range(0, 5);
         w_ev = 1'b0;
         no_write();
         wdata = $urandom;
         if (cfg_en_i && kind <= 2 && lvl + 4 <= 16) begin
            write_ev(wr_addr, 2'd2); w_ev = 1'b1;
         end else if (kind == 3) begin
            write_ev(wr_addr, 2'd2); spoof_dest_i = OTHER;
         end else if (kind == 4) begin
            write_ev(wr_addr, 2'd2); spoof_gnt_i = 1'b0;
         end
         tx_ch_gnt_i = 1'($urandom_range(0, 1));
         tx_ch_valid_i = (pend_q.size() > 0) && ($urandom_range(0, 2) != 0);
         tx_ch_data_i = tx_ch_valid_i ? pend_q[0] : 32'h0;
         out_stream_ready_i = ($urandom_range(0, 4) < 3);
         #1;
         exp_req = running && lvl >= 4 && (granted - popped) < 4;
         chk("req", tx_ch_req_o, exp_req);
         chk("oval", out_stream_valid_o, responded > popped);
         if (tx_ch_req_o && tx_ch_gnt_i) begin
            chk("rd_addr", tx_ch_addr_o, rd_exp);
            pend_q.push_back(mem[int'(rd_exp - 16'h0100) >> 2]);
            rd_exp = (rd_exp == 16'h010C) ? 16'h0100 : rd_exp + 16'd4;
            granted++; lvl -= 4;
         end
         if (out_stream_valid_o && out_stream_ready_i) begin
            if (exp_q.size() == 0) chk("rd_data_extra", 1, 0);
            else chk("rd_data", out_stream_data_o, exp_q.pop_front());
            chk("sot", out_stream_sot_o, first_beat);
            chk("ds_eot", {out_stream_datasize_o, out_stream_eot_o}, {2'd2, 1'b0});
            first_beat = 1'b0; popped++;
         end
         if (w_ev) begin
            mem[int'(wr_addr - 16'h0100) >> 2] = wdata;
            exp_q.push_back(wdata);
            wr_addr = (wr_addr == 16'h010C) ? 16'h0100 : wr_addr + 16'd4;
            lvl += 4; running = 1'b1;
         end
         if (tx_ch_valid_i) begin
            void'(pend_q.pop_front());
            responded++;
         end
         if (!cfg_en_i) running = 1'b0;
         tick();
      end
      chk("drain_done", granted - popped, 0);
      chk("drain_left", exp_q.size(), lvl / 4);
      drive_defaults();
      tick();
      in_stream_valid_i = 1'b1; in_stream_data_i = 32'hCAFE_0042; out_stream_ready_i = 1'b1;
      #1;
      chk("post_drain_pt", {out_stream_valid_o, out_stream_data_o}, {1'b1, 32'hCAFE_0042});
      chk("post_drain_rdy", in_stream_ready_o, 1);
      drive_defaults();

      // overrun and format errors, 16B ring, no reads granted
      clear();
      cfg_base_i = 16'h0100; cfg_size_i = 16'h0010; cfg_en_i = 1'b1;
      tick();
      for (int i = 0; i < 5; i++) begin
         write_ev(16'h0100 + 16'(4 * (i % 4)), 2'd2);
         tick();
         if (i == 0) begin
            chk("first_req", tx_ch_req_o, 1);
            chk("first_addr", tx_ch_addr_o, 16'h0100);
         end
         if (i == 3) chk("full_no_ovr", {err_overrun_o, level_o}, {1'b0, 17'd16});
      end
      no_write();
      #1;
      chk("ovr_flag", err_overrun_o, 1);
      chk("ovr_level", level_o, 16);
      chk("ovr_nofmt", err_fmt_o, 0);
      write_ev(16'h0100, 2'd1);
      tick();
      no_write();
      chk("fmt_flag", err_fmt_o, 1);
      chk("fmt_level", level_o, 16);
      clear();
      chk("clr_err", {err_overrun_o, err_fmt_o, level_o}, 0);

      // credit limit: 32 bytes pending, sink stalled
      cfg_base_i = 16'h0000; cfg_size_i = 16'h0040; cfg_en_i = 1'b1;
      tick();
      for (int i = 0; i < 8; i++) begin
         write_ev(16'(4 * i), 2'd2);
         tick();
      end
      no_write();
      #1;
      chk("cred_level", level_o, 32);
      ngr = 0; vnext = 1'b0; tx_ch_gnt_i = 1'b1; out_stream_ready_i = 1'b0;
      for (int i = 0; i < 12; i++) begin
         tx_ch_valid_i = vnext;
         tx_ch_data_i = 32'hC000_0000 + 32'(ngr - 1);
         #1;
         vnext = tx_ch_req_o;
         if (tx_ch_req_o) ngr++;
         tick();
      end
      tx_ch_valid_i = 1'b0;
      #1;
      chk("cred_grants", ngr, 4);
      chk("cred_hold", tx_ch_req_o, 0);
      out_stream_ready_i = 1'b1;
      #1;
      chk("cred_head", {out_stream_valid_o, out_stream_sot_o, out_stream_data_o}, {1'b1, 1'b1, 32'hC000_0000});
      tick();
      out_stream_ready_i = 1'b0;
      #1;
      chk("cred_resume", tx_ch_req_o, 1);
      tx_ch_gnt_i = 1'b0;

      // clear with two reads in flight; late data must be dropped
      clear();
      cfg_base_i = 16'h0000; cfg_size_i = 16'h0040; cfg_en_i = 1'b1;
      tick();
      for (int i = 0; i < 4; i++) begin
         write_ev(16'(4 * i), 2'd2);
         tick();
      end
      no_write();
      out_stream_ready_i = 1'b1; tx_ch_gnt_i = 1'b1;
      #1;
      chk("run_in_ready", in_stream_ready_o, 0);
      ngr = 0;
      for (int i = 0; i < 2; i++) begin
         #1;
         if (tx_ch_req_o) ngr++;
         tick();
      end
      chk("clr_inflight", ngr, 2);
      tx_ch_gnt_i = 1'b0;
      cfg_clr_i = 1'b1;
      tick();
      cfg_clr_i = 1'b0;
      tx_ch_valid_i = 1'b1; tx_ch_data_i = 32'hBAD0_0001;
      #1;
      chk("clr_level", level_o, 0);
      chk("clr_idle", in_stream_ready_o, 1);
      chk("clr_req", tx_ch_req_o, 0);
      tick();
      tx_ch_data_i = 32'hBAD0_0002;
      tick();
      tx_ch_valid_i = 1'b0;
      #1;
      chk("clr_fifo_empty", out_stream_valid_o, 0);
      chk("clr_armed", in_stream_ready_o, 0);
      chk("clr_level2", level_o, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
